fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NSRC, default 2, number of source operands checked per issued instruction.
REQ-002 Parameter DEPTH, default 3, number of tracked in-flight stages (stage 1 = youngest, EX/MEM equivalent).
REQ-003 Parameter AW, default 5, register address width.
REQ-004 Parameter LW, default 2, result-latency field width; SELW = clog2(DEPTH+1) is derived, not set.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 issue_valid  in  1  instruction in ID/EX requests to advance this cycle.
REQ-008 issue_we  in  1  issued instruction writes a destination register.
REQ-009 issue_rd  in  AW  destination register of issued instruction.
REQ-010 issue_lat  in  LW  cycles after entering stage 1 until its result can be forwarded (0 = ALU, 1 = load).
REQ-011 src_addr  in  NSRC*AW  packed source register addresses; operand k at bits [k*AW +: AW].
REQ-012 flush  in  1  discard all tracked entries.
REQ-013 fwd_sel  out  NSRC*SELW  per-operand select; 0 = register file, i = stage i result.
REQ-014 stall  out  1  issued instruction cannot advance; bubble inserted.
REQ-015 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-016 Tracker SHALL hold DEPTH entries {valid, we, rd, rem[LW]}, shifting stage i to i+1 each cycle; stage DEPTH's entry is dropped.
REQ-017 Stage 1 SHALL load {1, issue_we, issue_rd, issue_lat} when issue_valid && !stall && !flush, else an invalid bubble.
REQ-018 rem SHALL decrement by 1 per cycle while shifting, saturating at 0.
REQ-019 An entry matches operand k when valid && we && rd == src_addr[k] && rd != 0.
REQ-020 Per operand, the lowest-numbered (youngest) matching stage SHALL win; older matches are ignored.
REQ-021 If the winner has rem == 0, fwd_sel[k] SHALL equal its stage number; if no match, fwd_sel[k] = 0.
REQ-022 If the winner has rem != 0, operand k is blocked and fwd_sel[k] SHALL be 0.
REQ-023 stall SHALL equal issue_valid && (any operand blocked) && !flush.
REQ-024 fwd_sel and stall SHALL be combinational from current state and inputs (zero-cycle latency).
REQ-025 Register 0 SHALL never forward or stall, regardless of tracker contents.
REQ-026 issue_lat >= DEPTH SHALL be clamped to DEPTH-1 on load into stage 1.
REQ-027 flush SHALL invalidate every entry at the next edge and override issue and stall in that cycle.
REQ-028 stall_cnt SHALL increment once per cycle with stall = 1 and hold at 16'hFFFF.
REQ-029 Simultaneous stall and shift: older entries SHALL still shift and count down; only the issue is held.

Reset
REQ-030 rst SHALL asynchronously clear all entry valid bits, rem fields and stall_cnt to 0.
REQ-031 During and immediately after reset: fwd_sel = 0 for all operands, stall = 0, stall_cnt = 0.
REQ-032 Reset asserted mid-stall SHALL drop the stall immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package fwd_pkg SHALL hold default NSRC/DEPTH/AW/LW, the FWD_RF = 0 select constant and the entry struct typedef.
REQ-034 Per-operand priority match SHALL be one sub-module, fwd_match, instantiated NSRC times via generate.

Verification
REQ-035 ALU back-to-back: issue rd=5 lat=0, next cycle src0=5 -> fwd_sel[0]=1, stall=0.
REQ-036 Load-use: issue rd=7 lat=1, next cycle src1=7 -> stall=1, fwd_sel[1]=0; the following cycle -> stall=0, fwd_sel[1]=2, stall_cnt=1.
REQ-037 Youngest wins: rd=3 in stage 1 and stage 2, both rem=0, src0=3 -> fwd_sel[0]=1.
REQ-038 x0: issue rd=0 we=1, then src0=0 -> fwd_sel[0]=0, stall=0.
REQ-039 Flush: pending load rd=9 lat=1 with src0=9 stalled, flush=1 -> stall=0; next cycle src0=9 -> fwd_sel[0]=0.
REQ-040 Async reset mid-stall: rst raised between edges -> stall=0 and stall_cnt=0 with no clock edge; stall_cnt saturates at 16'hFFFF after 65536+ stalled cycles.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared defaults, select encoding and tracker entry type for the forwarding scoreboard.
package fwd_pkg;

    localparam int NSRC_DEF  = 2;
    localparam int DEPTH_DEF = 3;
    localparam int AW_DEF    = 5;
    localparam int LW_DEF    = 2;
    localparam int FWD_RF    = 0;

    // Fields sized for the widest supported configuration (AW <= 8, LW <= 8).
    localparam int RD_MAX  = 8;
    localparam int REM_MAX = 8;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic [RD_MAX-1:0]  rd;
        logic [REM_MAX-1:0] rem;
    } fwd_entry_t;

    function automatic fwd_entry_t fwd_age(input fwd_entry_t e);
        fwd_entry_t a;
        a     = e;
        a.rem = (e.rem != REM_MAX'(0)) ? e.rem - REM_MAX'(1) : REM_MAX'(0);
        return a;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/operand/forward-select bundle between the pipeline and the scoreboard.
interface fwd_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int AW   = AW_DEF,
    parameter int LW   = LW_DEF,
    parameter int SELW = $clog2(DEPTH_DEF + 1)
);
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_rd;
    logic [LW-1:0]        issue_lat;
    logic [NSRC*AW-1:0]   src_addr;
    logic                 flush;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall;
    logic [15:0]          stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat, src_addr, flush,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat, src_addr, flush,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// Per-operand priority search over the tracker: youngest matching stage decides
// between forwarding from that stage and blocking the operand.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int SELW  = $clog2(DEPTH_DEF + 1)
) (
    input  fwd_entry_t [DEPTH-1:0] stages,
    input  logic [AW-1:0]          src_addr,
    output logic [SELW-1:0]        sel,
    output logic                   blocked
);

    logic hit_s;
    logic pend_s;

    // Walk oldest to youngest so a younger hit overrides any older one.
    always_comb begin
        sel     = SELW'(FWD_RF);
        blocked = 1'b0;
        hit_s   = 1'b0;
        pend_s  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_s   = stages[i].valid && stages[i].we &&
                      (stages[i].rd == RD_MAX'(src_addr)) && (src_addr != AW'(0));
            pend_s  = (stages[i].rem != REM_MAX'(0));
            blocked = hit_s ? pend_s : blocked;
            sel     = hit_s ? (pend_s ? SELW'(FWD_RF) : SELW'(i + 1)) : sel;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight result tracker producing per-operand forward selects, the issue
// stall and a saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NSRC  = NSRC_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int LW    = LW_DEF
) (
    input logic             clk,
    input logic             rst,
    fwd_scoreboard_if.slave bus
);

    localparam int SELW = $clog2(DEPTH + 1);

    fwd_entry_t [DEPTH-1:0] stages_r;
    fwd_entry_t             head_s;
    logic [LW-1:0]          lat_clamped_s;
    logic [NSRC-1:0]        blocked_s;
    logic [SELW-1:0]        sel_s [NSRC];
    logic [NSRC*SELW-1:0]   sel_flat_s;
    logic                   stall_s;
    logic [15:0]            stall_cnt_r;

    // A latency that would outlive the tracker is capped so the entry still ripens in view.
    assign lat_clamped_s = (int'(bus.issue_lat) >= DEPTH) ? LW'(DEPTH - 1) : bus.issue_lat;

    for (genvar k = 0; k < NSRC; k++) begin : g_match
        fwd_match #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .SELW  (SELW)
        ) u_match (
            .stages   (stages_r),
            .src_addr (bus.src_addr[k*AW +: AW]),
            .sel      (sel_s[k]),
            .blocked  (blocked_s[k])
        );
        assign sel_flat_s[k*SELW +: SELW] = sel_s[k];
    end

    assign stall_s       = bus.issue_valid && (|blocked_s) && !bus.flush;
    assign bus.stall     = stall_s;
    assign bus.fwd_sel   = sel_flat_s;
    assign bus.stall_cnt = stall_cnt_r;

    // Entry entering stage 1: the issued instruction, or a bubble when held or flushed.
    always_comb begin
        head_s = '0;
        if (bus.issue_valid && !stall_s && !bus.flush) begin
            head_s.valid = 1'b1;
            head_s.we    = bus.issue_we;
            head_s.rd    = RD_MAX'(bus.issue_rd);
            head_s.rem   = REM_MAX'(lat_clamped_s);
        end else begin
            head_s = '0;
        end
    end

    // Tracker shift; older entries keep aging even while the issue is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages_r <= '0;
        end else if (bus.flush) begin
            stages_r <= '0;
        end else begin
            stages_r[0] <= head_s;
            for (int i = 1; i < DEPTH; i++) begin
                stages_r[i] <= fwd_age(stages_r[i-1]);
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against an issue-history model;
// a second deep instance exercises stall counter saturation.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int AW    = 5;
    localparam int LW    = 2;
    localparam int SELW  = 2;
    localparam int SDEPTH = 16;
    localparam int SLW    = 4;
    localparam int SSELW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NSRC(NSRC), .AW(AW), .LW(LW),  .SELW(SELW))  bus ();
    fwd_scoreboard_if #(.NSRC(NSRC), .AW(AW), .LW(SLW), .SELW(SSELW)) sbus ();

    fwd_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    fwd_scoreboard #(.NSRC(NSRC), .DEPTH(SDEPTH), .AW(AW), .LW(SLW)) sat (
        .clk (clk), .rst (rst), .bus (sbus)
    );

    typedef struct { bit v; bit we; int rd; int lat; } iss_t;

    // hist[i] is what was issued (i+1) clock edges ago.
    iss_t hist[$];
    int   m_cnt;
    int   checks;
    int   errors;
    bit   drv_iv, drv_we, drv_fl;
    int   drv_rd, drv_lat;
    int   drv_src [NSRC];
    int   exp_sel [NSRC];
    bit   exp_stall;
    int   se;
    int   m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_of(input int k);
        return 32'(bus.fwd_sel[k*SELW +: SELW]);
    endfunction

    function automatic void model_eval();
        bit blk;
        int lat;
        blk = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            exp_sel[k] = FWD_RF;
            if (drv_src[k] != 0) begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i].v && hist[i].we && hist[i].rd == drv_src[k]) begin
                        lat = (hist[i].lat >= DEPTH) ? DEPTH - 1 : hist[i].lat;
                        if (i < lat) blk = 1'b1;
                        else exp_sel[k] = i + 1;
                        break;
                    end
                end
            end
        end
        exp_stall = drv_iv && blk && !drv_fl;
    endfunction

    function automatic void model_clock();
        iss_t e;
        if (drv_fl) begin
            hist.delete();
        end else begin
            e.v   = drv_iv && !exp_stall;
            e.we  = drv_we;
            e.rd  = drv_rd;
            e.lat = drv_lat;
            hist.push_front(e);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        if (exp_stall && m_cnt < 65535) m_cnt++;
    endfunction

    task automatic step(input bit iv, input bit we, input int rd, input int lat,
                        input int s0, input int s1, input bit fl);
        drv_iv = iv; drv_we = we; drv_rd = rd; drv_lat = lat; drv_fl = fl;
        drv_src[0] = s0; drv_src[1] = s1;
        bus.issue_valid = iv;
        bus.issue_we    = we;
        bus.issue_rd    = AW'(rd);
        bus.issue_lat   = LW'(lat);
        bus.src_addr    = {AW'(s1), AW'(s0)};
        bus.flush       = fl;
        #1;
        model_eval();
        for (int k = 0; k < NSRC; k++) chk($sformatf("model_sel%0d", k), sel_of(k), 32'(exp_sel[k]));
        chk("model_stall", 32'(bus.stall), 32'(exp_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        chk("model_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; m_cnt = 0;
        sbus.issue_valid = 1'b0; sbus.issue_we = 1'b0; sbus.issue_rd = '0;
        sbus.issue_lat = '0; sbus.src_addr = '0; sbus.flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_sel1", sel_of(1), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();

        // ALU back-to-back
        step(1'b1, 1'b1, 5, 0, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 6, 0, 5, 0, 1'b0);
        chk("alu_sel0", sel_of(0), 32'd1);
        chk("alu_stall", 32'(bus.stall), 32'd0);
        tick();

        // load-use
        step(1'b1, 1'b1, 7, 1, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 8, 0, 0, 7, 1'b0);
        chk("lu_stall", 32'(bus.stall), 32'd1);
        chk("lu_sel1", sel_of(1), 32'd0);
        tick();
        step(1'b1, 1'b1, 8, 0, 0, 7, 1'b0);
        chk("lu2_stall", 32'(bus.stall), 32'd0);
        chk("lu2_sel1", sel_of(1), 32'd2);
        chk("lu2_cnt", 32'(bus.stall_cnt), 32'd1);
        tick();

        // youngest wins
        step(1'b1, 1'b1, 3, 0, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 3, 0, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 0, 0, 3, 0, 1'b0);
        chk("yw_sel0", sel_of(0), 32'd1);
        tick();

        // x0 never forwards
        step(1'b1, 1'b0, 1, 0, 0, 0, 1'b0);
        chk("x0_sel0", sel_of(0), 32'd0);
        chk("x0_stall", 32'(bus.stall), 32'd0);
        tick();

        // flush overrides a load-use stall
        step(1'b1, 1'b1, 9, 1, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 4, 0, 9, 0, 1'b0);
        chk("fl_pre_stall", 32'(bus.stall), 32'd1);
        step(1'b1, 1'b1, 4, 0, 9, 0, 1'b1);
        chk("fl_stall", 32'(bus.stall), 32'd0);
        tick();
        step(1'b1, 1'b1, 4, 0, 9, 0, 1'b0);
        chk("fl_sel0", sel_of(0), 32'd0);
        tick();

        // latency 3 is capped at 2 with DEPTH 3
        step(1'b1, 1'b1, 12, 3, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 13, 0, 12, 0, 1'b0);
        chk("clamp_stall1", 32'(bus.stall), 32'd1);
        tick();
        step(1'b1, 1'b1, 13, 0, 12, 0, 1'b0);
        chk("clamp_stall2", 32'(bus.stall), 32'd1);
        tick();
        step(1'b1, 1'b1, 13, 0, 12, 0, 1'b0);
        chk("clamp_sel0", sel_of(0), 32'd3);
        chk("clamp_go", 32'(bus.stall), 32'd0);
        tick();

        // async reset between edges while stalled
        step(1'b1, 1'b1, 14, 1, 0, 0, 1'b0); tick();
        step(1'b1, 1'b1, 15, 0, 0, 14, 1'b0);
        chk("ar_pre_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_stall", 32'(bus.stall), 32'd0);
        chk("ar_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("ar_sel1", sel_of(1), 32'd0);
        hist.delete();
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 15) == 0));
            tick();
        end

        // saturation: constant load-use on a deep tracker stalls 15 of every 16 cycles
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        sbus.issue_valid = 1'b1;
        sbus.issue_we    = 1'b1;
        sbus.issue_rd    = AW'(1);
        sbus.issue_lat   = SLW'(15);
        sbus.src_addr    = {AW'(0), AW'(1)};
        for (int n = 1; n <= 70010; n++) begin
            @(posedge clk);
            #1;
            m  = n - 1;
            se = m - m / 16;
            if (se > 65535) se = 65535;
            if (n == 1) chk("sat_stall_c1", 32'(sbus.stall), 32'd1);
            if (n == 16) begin
                chk("sat_stall_c16", 32'(sbus.stall), 32'd0);
                chk("sat_sel_c16", 32'(sbus.fwd_sel[SSELW-1:0]), 32'd16);
            end
            if (n == 17 || n == 40001 || n == 69903 || n == 69904 || n == 70010)
                chk($sformatf("sat_cnt_%0d", n), 32'(sbus.stall_cnt), 32'(se));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
